// File: rtl/clusterv_wb_dma.sv
// Single-channel Wishbone word-copy DMA: a 4-register target port for programming
// and an initiator port that copies LEN words from SRC to DST with single transfers.
module clusterv_wb_dma #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] regs_adr,
  input  logic [31:0] regs_dat_w,
  output logic [31:0] regs_dat_r,
  input  logic        regs_cyc,
  input  logic        regs_stb,
  input  logic        regs_we,
  input  logic [3:0]  regs_sel,
  output logic        regs_ack,
  output logic        regs_err,
  output logic [31:0] dma_adr,
  output logic [31:0] dma_dat_w,
  input  logic [31:0] dma_dat_r,
  output logic        dma_cyc,
  output logic        dma_stb,
  output logic        dma_we,
  output logic [3:0]  dma_sel,
  input  logic        dma_ack,
  input  logic        dma_err,
  output logic        irq
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_RGAP,
    S_WRITE,
    S_WGAP
  } state_e;

  state_e               state_q;
  logic [DW-1:0]        src_q;
  logic [DW-1:0]        dst_q;
  logic [DW-1:0]        buf_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 done_q;
  logic                 err_q;
  logic                 regs_ack_q;
  logic [DW-1:0]        regs_dat_r_q;
  logic [DW-1:0]        dma_adr_q;
  logic [DW-1:0]        dma_dat_w_q;
  logic                 dma_cyc_q;
  logic                 dma_stb_q;
  logic                 dma_we_q;
  logic [3:0]           dma_sel_q;

  logic                 acc_c;
  logic                 wr_c;
  logic                 busy_c;
  logic [1:0]           idx_c;
  logic [DW-1:0]        rd_c;
  logic                 unused_c;

  assign acc_c  = regs_cyc & regs_stb & ~regs_ack_q;
  assign wr_c   = acc_c & regs_we;
  assign busy_c = (state_q != S_IDLE);
  assign idx_c  = regs_adr[3:2];

  // Byte selects and the undecoded address/data bits carry no meaning here.
  assign unused_c = ^{regs_adr[31:4], regs_adr[1:0], regs_sel, regs_dat_w};

  // Register read mux, sampled into regs_dat_r on the acknowledging edge.
  always_comb begin
    rd_c = '0;
    case (idx_c)
      2'd0:    rd_c = src_q;
      2'd1:    rd_c = dst_q;
      2'd2:    rd_c = DW'(len_q);
      default: rd_c = {29'b0, err_q, done_q, busy_c};
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      buf_q        <= '0;
      len_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      regs_ack_q   <= 1'b0;
      regs_dat_r_q <= '0;
      dma_adr_q    <= '0;
      dma_dat_w_q  <= '0;
      dma_cyc_q    <= 1'b0;
      dma_stb_q    <= 1'b0;
      dma_we_q     <= 1'b0;
      dma_sel_q    <= 4'h0;
    end else begin
      regs_ack_q <= acc_c;
      if (acc_c) begin
        regs_dat_r_q <= rd_c;
      end

      // Register writes; address/length are frozen while a copy is running.
      if (wr_c) begin
        case (idx_c)
          2'd0: if (!busy_c) src_q <= {regs_dat_w[31:2], 2'b00};
          2'd1: if (!busy_c) dst_q <= {regs_dat_w[31:2], 2'b00};
          2'd2: if (!busy_c) len_q <= regs_dat_w[LEN_WIDTH-1:0];
          default: begin
            if (regs_dat_w[1]) done_q <= 1'b0;
            if (regs_dat_w[2]) err_q  <= 1'b0;
            if (regs_dat_w[0] && !busy_c) begin
              if (len_q == '0) begin
                done_q <= 1'b1;
              end else begin
                done_q    <= 1'b0;
                err_q     <= 1'b0;
                state_q   <= S_READ;
                dma_cyc_q <= 1'b1;
                dma_stb_q <= 1'b1;
                dma_we_q  <= 1'b0;
                dma_sel_q <= 4'hF;
                dma_adr_q <= src_q;
              end
            end
          end
        endcase
      end

      // Copy engine; placed after the register writes so its done/err updates win.
      case (state_q)
        S_READ: begin
          if (dma_err) begin
            dma_cyc_q <= 1'b0;
            dma_stb_q <= 1'b0;
            dma_sel_q <= 4'h0;
            err_q     <= 1'b1;
            state_q   <= S_IDLE;
          end else if (dma_ack) begin
            buf_q     <= dma_dat_r;
            dma_cyc_q <= 1'b0;
            dma_stb_q <= 1'b0;
            dma_sel_q <= 4'h0;
            state_q   <= S_RGAP;
          end
        end
        S_RGAP: begin
          dma_cyc_q   <= 1'b1;
          dma_stb_q   <= 1'b1;
          dma_we_q    <= 1'b1;
          dma_sel_q   <= 4'hF;
          dma_adr_q   <= dst_q;
          dma_dat_w_q <= buf_q;
          state_q     <= S_WRITE;
        end
        S_WRITE: begin
          if (dma_err) begin
            dma_cyc_q <= 1'b0;
            dma_stb_q <= 1'b0;
            dma_sel_q <= 4'h0;
            err_q     <= 1'b1;
            state_q   <= S_IDLE;
          end else if (dma_ack) begin
            dma_cyc_q <= 1'b0;
            dma_stb_q <= 1'b0;
            dma_sel_q <= 4'h0;
            src_q     <= src_q + DW'(4);
            dst_q     <= dst_q + DW'(4);
            len_q     <= len_q - LEN_WIDTH'(1);
            state_q   <= S_WGAP;
          end
        end
        S_WGAP: begin
          if (len_q != '0) begin
            dma_cyc_q <= 1'b1;
            dma_stb_q <= 1'b1;
            dma_we_q  <= 1'b0;
            dma_sel_q <= 4'hF;
            dma_adr_q <= src_q;
            state_q   <= S_READ;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign regs_dat_r = regs_dat_r_q;
  assign regs_ack   = regs_ack_q;
  assign regs_err   = 1'b0;
  assign dma_adr    = dma_adr_q;
  assign dma_dat_w  = dma_dat_w_q;
  assign dma_cyc    = dma_cyc_q;
  assign dma_stb    = dma_stb_q;
  assign dma_we     = dma_we_q;
  assign dma_sel    = dma_sel_q;
  assign irq        = done_q | err_q;

endmodule

// File: tb/tb_clusterv_wb_dma.sv
// Directed bench for clusterv_wb_dma: register master, Wishbone memory responder
// with programmable wait states / error injection, and a transfer log.
module tb_clusterv_wb_dma;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] regs_adr = '0;
  logic [31:0] regs_dat_w = '0;
  logic [31:0] regs_dat_r;
  logic        regs_cyc = 1'b0;
  logic        regs_stb = 1'b0;
  logic        regs_we = 1'b0;
  logic [3:0]  regs_sel = 4'hF;
  logic        regs_ack;
  logic        regs_err;
  logic [31:0] dma_adr;
  logic [31:0] dma_dat_w;
  logic [31:0] dma_dat_r = '0;
  logic        dma_cyc;
  logic        dma_stb;
  logic        dma_we;
  logic [3:0]  dma_sel;
  logic        dma_ack = 1'b0;
  logic        dma_err = 1'b0;
  logic        irq;

  int nvec = 0;
  int nerr = 0;

  clusterv_wb_dma #(.LEN_WIDTH(16)) dut (
    .clock(clock), .reset(reset),
    .regs_adr(regs_adr), .regs_dat_w(regs_dat_w), .regs_dat_r(regs_dat_r),
    .regs_cyc(regs_cyc), .regs_stb(regs_stb), .regs_we(regs_we),
    .regs_sel(regs_sel), .regs_ack(regs_ack), .regs_err(regs_err),
    .dma_adr(dma_adr), .dma_dat_w(dma_dat_w), .dma_dat_r(dma_dat_r),
    .dma_cyc(dma_cyc), .dma_stb(dma_stb), .dma_we(dma_we), .dma_sel(dma_sel),
    .dma_ack(dma_ack), .dma_err(dma_err), .irq(irq)
  );

  always #5 clock = ~clock;

  // Responder state and transfer log
  int          ws_tab[6];
  int          err_on_rd = 0;
  bit          fixed_en = 1'b0;
  logic [31:0] fixed_dat = '0;
  int          cyc_cnt = 0;
  int          cyc_high_cnt = 0;
  int          gap_viol = 0;
  int          stab_viol = 0;
  int          txn_n = 0;
  int          rd_n = 0;
  int          wait_cnt = 0;
  bit          in_txn = 1'b0;
  logic [31:0] hold_adr = '0;
  logic [31:0] lg_adr[$];
  logic [31:0] lg_dat[$];
  logic [3:0]  lg_sel[$];
  bit          lg_we[$];
  int          lg_t[$];

  always @(posedge clock) begin
    #1;
    cyc_cnt++;
    if (dma_cyc) cyc_high_cnt++;
    if (dma_ack || dma_err) begin
      dma_ack = 1'b0;
      dma_err = 1'b0;
      if (dma_cyc) gap_viol++;
    end else if (dma_cyc && dma_stb) begin
      if (!in_txn) begin
        in_txn   = 1'b1;
        hold_adr = dma_adr;
        wait_cnt = 0;
      end else if (dma_adr !== hold_adr) begin
        stab_viol++;
      end
      if (wait_cnt < ws_tab[txn_n % 6]) begin
        wait_cnt++;
      end else begin
        in_txn = 1'b0;
        lg_adr.push_back(dma_adr);
        lg_dat.push_back(dma_dat_w);
        lg_sel.push_back(dma_sel);
        lg_we.push_back(dma_we);
        lg_t.push_back(cyc_cnt);
        txn_n++;
        if (!dma_we) begin
          rd_n++;
          if (rd_n == err_on_rd) begin
            dma_err = 1'b1;
          end else begin
            dma_ack   = 1'b1;
            dma_dat_r = fixed_en ? fixed_dat : (dma_adr ^ 32'h5A5A_1234);
          end
        end else begin
          dma_ack = 1'b1;
        end
      end
    end
  end

  task automatic clear_log();
    lg_adr.delete(); lg_dat.delete(); lg_sel.delete(); lg_we.delete(); lg_t.delete();
    txn_n = 0; rd_n = 0; gap_viol = 0; stab_viol = 0; cyc_high_cnt = 0;
  endtask

  task automatic set_ws(input int a, input int b, input int c, input int d,
                        input int e, input int f);
    ws_tab[0] = a; ws_tab[1] = b; ws_tab[2] = c;
    ws_tab[3] = d; ws_tab[4] = e; ws_tab[5] = f;
  endtask

  task automatic reg_rw(input logic we, input logic [1:0] idx, input logic [31:0] wd,
                        output logic [31:0] rd);
    int n;
    @(posedge clock); #1;
    regs_cyc = 1'b1; regs_stb = 1'b1; regs_we = we;
    regs_adr = {28'h0, idx, 2'b00}; regs_dat_w = wd;
    n = 0;
    do begin
      @(posedge clock); #1; n++;
    end while (!regs_ack && n < 20);
    if (!regs_ack) begin
      nvec++; nerr++;
      $display("FAIL reg_ack_timeout: idx=%0d no ack after %0d cycles", idx, n);
    end
    rd = regs_dat_r;
    regs_cyc = 1'b0; regs_stb = 1'b0; regs_we = 1'b0;
  endtask

  task automatic wait_idle();
    logic [31:0] r;
    int n;
    n = 0;
    do begin
      reg_rw(1'b0, 2'd3, 32'h0, r); n++;
    end while (r[0] && n < 500);
    if (r[0]) begin
      nvec++; nerr++;
      $display("FAIL busy_timeout: still busy after %0d polls", n);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    #3 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    nvec++;
    if ({regs_ack, regs_err, dma_cyc, dma_stb, dma_we, irq} !== 6'b0) begin
      nerr++;
      $display("FAIL reset_ctl: got %b want 000000",
               {regs_ack, regs_err, dma_cyc, dma_stb, dma_we, irq});
    end
    nvec++;
    if ({regs_dat_r, dma_adr, dma_dat_w, dma_sel} !== 100'b0) begin
      nerr++;
      $display("FAIL reset_data: dat_r=%h adr=%h dat_w=%h sel=%h want all 0",
               regs_dat_r, dma_adr, dma_dat_w, dma_sel);
    end
    @(negedge clock) reset = 1'b1;
    reg_rw(1'b0, 2'd3, 32'h0, r);
    nvec++;
    if (r !== 32'h0) begin nerr++; $display("FAIL reset_ctrl_rd: got %h want 00000000", r); end
    reg_rw(1'b0, 2'd2, 32'h0, r);
    nvec++;
    if (r !== 32'h0) begin nerr++; $display("FAIL reset_len_rd: got %h want 00000000", r); end
  endtask

  task automatic test_single();
    logic [31:0] r;
    clear_log(); set_ws(0, 0, 0, 0, 0, 0);
    fixed_en = 1'b1; fixed_dat = 32'hDEAD_BEEF;
    reg_rw(1'b1, 2'd0, 32'h8000_0000, r);
    reg_rw(1'b1, 2'd1, 32'h8000_0100, r);
    reg_rw(1'b1, 2'd2, 32'h1, r);
    reg_rw(1'b1, 2'd3, 32'h1, r);
    wait_idle();
    fixed_en = 1'b0;
    nvec++;
    if (lg_adr.size() != 2) begin
      nerr++; $display("FAIL single_count: got %0d transfers want 2", lg_adr.size());
    end else begin
      nvec++;
      if ({lg_we[0], lg_adr[0], lg_sel[0]} !== {1'b0, 32'h8000_0000, 4'hF}) begin
        nerr++; $display("FAIL single_read: we=%b adr=%h sel=%h want 0 80000000 f",
                         lg_we[0], lg_adr[0], lg_sel[0]);
      end
      nvec++;
      if ({lg_we[1], lg_adr[1], lg_dat[1], lg_sel[1]} !==
          {1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'hF}) begin
        nerr++; $display("FAIL single_write: we=%b adr=%h dat=%h sel=%h want 1 80000100 deadbeef f",
                         lg_we[1], lg_adr[1], lg_dat[1], lg_sel[1]);
      end
      nvec++;
      if (lg_t[1] - lg_t[0] != 2) begin
        nerr++; $display("FAIL single_spacing: got %0d cycles want 2", lg_t[1] - lg_t[0]);
      end
    end
    reg_rw(1'b0, 2'd3, 32'h0, r);
    nvec++;
    if (r !== 32'h2) begin nerr++; $display("FAIL single_status: got %h want 00000002", r); end
    nvec++;
    if (irq !== 1'b1) begin nerr++; $display("FAIL single_irq: got %b want 1", irq); end
    reg_rw(1'b0, 2'd2, 32'h0, r);
    nvec++;
    if (r !== 32'h0) begin nerr++; $display("FAIL single_len: got %h want 00000000", r); end
  endtask

  task automatic test_burst();
    logic [31:0] r;
    logic [31:0] exp_dat[4];
    exp_dat[0] = 32'h5A5A_0234; exp_dat[1] = 32'h5A5A_0230;
    exp_dat[2] = 32'h5A5A_023C; exp_dat[3] = 32'h5A5A_0238;
    clear_log(); set_ws(0, 3, 1, 5, 2, 4);
    reg_rw(1'b1, 2'd0, 32'h0000_1000, r);
    reg_rw(1'b1, 2'd1, 32'h0000_2000, r);
    reg_rw(1'b1, 2'd2, 32'h4, r);
    reg_rw(1'b1, 2'd3, 32'h1, r);
    wait_idle();
    nvec++;
    if (lg_adr.size() != 8) begin
      nerr++; $display("FAIL burst_count: got %0d transfers want 8", lg_adr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
        if ({lg_we[2*i], lg_adr[2*i]} !== {1'b0, 32'h0000_1000 + 32'(4*i)}) begin
          nerr++; $display("FAIL burst_read%0d: we=%b adr=%h want 0 %h", i,
                           lg_we[2*i], lg_adr[2*i], 32'h0000_1000 + 32'(4*i));
        end
        nvec++;
        if ({lg_we[2*i+1], lg_adr[2*i+1], lg_dat[2*i+1]} !==
            {1'b1, 32'h0000_2000 + 32'(4*i), exp_dat[i]}) begin
          nerr++; $display("FAIL burst_write%0d: we=%b adr=%h dat=%h want 1 %h %h", i,
                           lg_we[2*i+1], lg_adr[2*i+1], lg_dat[2*i+1],
                           32'h0000_2000 + 32'(4*i), exp_dat[i]);
        end
      end
    end
    nvec++;
    if (gap_viol != 0 || stab_viol != 0) begin
      nerr++; $display("FAIL burst_gap_stable: gap=%0d unstable=%0d want 0 0", gap_viol, stab_viol);
    end
    reg_rw(1'b0, 2'd0, 32'h0, r);
    nvec++;
    if (r !== 32'h0000_1010) begin nerr++; $display("FAIL burst_src: got %h want 00001010", r); end
    reg_rw(1'b0, 2'd1, 32'h0, r);
    nvec++;
    if (r !== 32'h0000_2010) begin nerr++; $display("FAIL burst_dst: got %h want 00002010", r); end
  endtask

  task automatic test_error();
    logic [31:0] r;
    clear_log(); set_ws(0, 0, 0, 0, 0, 0);
    err_on_rd = 2;
    reg_rw(1'b1, 2'd0, 32'h0000_3000, r);
    reg_rw(1'b1, 2'd1, 32'h0000_4000, r);
    reg_rw(1'b1, 2'd2, 32'h3, r);
    reg_rw(1'b1, 2'd3, 32'h1, r);
    wait_idle();
    err_on_rd = 0;
    reg_rw(1'b0, 2'd3, 32'h0, r);
    nvec++;
    if (r !== 32'h4) begin nerr++; $display("FAIL err_status: got %h want 00000004", r); end
    reg_rw(1'b0, 2'd2, 32'h0, r);
    nvec++;
    if (r !== 32'h2) begin nerr++; $display("FAIL err_len: got %h want 00000002", r); end
    reg_rw(1'b0, 2'd0, 32'h0, r);
    nvec++;
    if (r !== 32'h0000_3004) begin nerr++; $display("FAIL err_src: got %h want 00003004", r); end
    nvec++;
    if (irq !== 1'b1) begin nerr++; $display("FAIL err_irq: got %b want 1", irq); end
    reg_rw(1'b1, 2'd3, 32'h4, r);
    reg_rw(1'b0, 2'd3, 32'h0, r);
    nvec++;
    if (r !== 32'h0 || irq !== 1'b0) begin
      nerr++; $display("FAIL err_clear: status=%h irq=%b want 00000000 0", r, irq);
    end
  endtask

  task automatic test_len0();
    logic [31:0] r;
    clear_log();
    reg_rw(1'b1, 2'd2, 32'h0, r);
    reg_rw(1'b1, 2'd3, 32'h1, r);
    nvec++;
    if (irq !== 1'b1) begin nerr++; $display("FAIL len0_irq: got %b want 1", irq); end
    repeat (6) @(posedge clock);
    reg_rw(1'b0, 2'd3, 32'h0, r);
    nvec++;
    if (r !== 32'h2) begin nerr++; $display("FAIL len0_status: got %h want 00000002", r); end
    nvec++;
    if (cyc_high_cnt != 0) begin
      nerr++; $display("FAIL len0_nobus: cyc high %0d cycles want 0", cyc_high_cnt);
    end
  endtask

  task automatic test_busy_protect();
    logic [31:0] r;
    clear_log(); set_ws(2, 2, 2, 2, 2, 2);
    reg_rw(1'b1, 2'd0, 32'h0000_5000, r);
    reg_rw(1'b1, 2'd1, 32'h0000_6000, r);
    reg_rw(1'b1, 2'd2, 32'h2, r);
    reg_rw(1'b1, 2'd3, 32'h1, r);
    reg_rw(1'b1, 2'd0, 32'h1234_5678, r);
    reg_rw(1'b1, 2'd3, 32'h1, r);
    wait_idle();
    nvec++;
    if (lg_adr.size() != 4) begin
      nerr++; $display("FAIL busy_count: got %0d transfers want 4", lg_adr.size());
    end else begin
      nvec++;
      if ({lg_adr[0], lg_adr[1], lg_adr[2], lg_adr[3]} !==
          {32'h0000_5000, 32'h0000_6000, 32'h0000_5004, 32'h0000_6004}) begin
        nerr++; $display("FAIL busy_addrs: got %h %h %h %h want 00005000 00006000 00005004 00006004",
                         lg_adr[0], lg_adr[1], lg_adr[2], lg_adr[3]);
      end
    end
    reg_rw(1'b0, 2'd0, 32'h0, r);
    nvec++;
    if (r !== 32'h0000_5008) begin nerr++; $display("FAIL busy_src_end: got %h want 00005008", r); end
    reg_rw(1'b1, 2'd0, 32'h1234_5677, r);
    reg_rw(1'b0, 2'd0, 32'h0, r);
    nvec++;
    if (r !== 32'h1234_5674) begin nerr++; $display("FAIL idle_src_align: got %h want 12345674", r); end
  endtask

  initial begin
    set_ws(0, 0, 0, 0, 0, 0);
    test_reset();
    test_single();
    test_burst();
    test_error();
    test_len0();
    test_busy_protect();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/clusterv_wb_dma.md
Name: clusterv_wb_dma

Overview:
- Single-channel word-copy DMA engine for the clusterv SoC.
- It acts as a Wishbone initiator into the main tag interconnect, the counterpart to the SRAM, flash and peripheral responders.
- Software programs it through a 4-register Wishbone target port. It copies LEN 32-bit words from SRC to DST using single read/write transfers.
- It is instanced in the peripheral subsystem, driving the DMA initiator slot.

Parameters:
LEN_WIDTH, 16, width of the word-count register; max transfer is 2^LEN_WIDTH-1 words.

Ports:
clock  input  1  system clock; all logic is on the rising edge.
reset  input  1  asynchronous reset, active-low (0 = in reset); deassertion is synchronous to clock externally.
regs_adr  input  32  register target address; only [3:2] are decoded.
regs_dat_w  input  32  register write data.
regs_dat_r  output  32  register read data.
regs_cyc  input  1  target cycle.
regs_stb  input  1  target strobe.
regs_we  input  1  target write enable.
regs_sel  input  4  byte selects; ignored, full-word access only.
regs_ack  output  1  target acknowledge.
regs_err  output  1  target error; tied 0.
dma_adr  output  32  initiator address.
dma_dat_w  output  32  initiator write data.
dma_dat_r  input  32  initiator read data.
dma_cyc  output  1  initiator cycle.
dma_stb  output  1  initiator strobe.
dma_we  output  1  initiator write enable.
dma_sel  output  4  initiator byte selects; always 4'hF when stb=1, else 0.
dma_ack  input  1  initiator acknowledge.
dma_err  input  1  initiator error.
irq  output  1  level interrupt = done | err.

Behaviour:
- Reset (reset=0): SRC, DST, LEN, done, err, data buffer = 0; state IDLE. All outputs 0: regs_dat_r, regs_ack, dma_* outputs, irq.
- Register map (regs_adr[3:2]):
  - 0 SRC: write forces [1:0]=0.
  - 1 DST: write forces [1:0]=0.
  - 2 LEN: reads return the live remaining count, zero-extended.
  - 3 CTRL/STATUS:
    - write: bit0=start; bit1=1 clears done; bit2=1 clears err.
    - read: {29'b0, err, done, busy}.
- Target handshake:
  - When regs_cyc&regs_stb&!regs_ack, regs_ack=1 on the next cycle for exactly one cycle; the write takes effect on that edge.
  - regs_dat_r is registered with ack and holds its value otherwise.
  - Back-to-back accesses are acked every other cycle.
- Writes to SRC/DST/LEN while busy are ignored, but still acked. Start while busy is ignored.
- Start while IDLE:
  - LEN==0: no bus activity; done set next cycle.
  - Otherwise: go to READ and clear done and err.
  - A start written together with bit1/bit2 in the same write: the start wins; done and err are cleared.
- State machine IDLE -> READ -> RGAP -> WRITE -> WGAP -> (READ | IDLE):
  - READ: dma_cyc=stb=1, we=0, adr=SRC. When ack is sampled, latch dma_dat_r into the buffer and go to RGAP.
  - RGAP: cyc/stb=0 for one cycle.
  - WRITE: cyc=stb=1, we=1, adr=DST, dat_w=buffer.
  - On write ack: SRC+=4, DST+=4 (mod 2^32, wrap silently), LEN-=1, then go to WGAP.
  - WGAP: one cycle, then READ if LEN!=0; else IDLE and set done.
- All dma_* outputs are registered. cyc/stb/adr/we/dat_w are stable from assertion until the cycle after ack.
- Minimum per-word time, with ack on the first cycle of each phase: 4 cycles (READ, RGAP, WRITE, WGAP).
- dma_err sampled in READ or WRITE (err takes priority over ack if both are high):
  - Drop cyc/stb next cycle, set err, return to IDLE.
  - SRC/DST/LEN keep their values from the failing word, so software can restart.
- busy = (state != IDLE).
- irq is combinational from the sticky done/err bits.

Test Plan:
- Reset: with reset=0, all outputs are 0. After release, reading CTRL returns 0 and reading LEN returns 0.
- Single word:
  - Setup: SRC=0x80000000, DST=0x80000100, LEN=1, start. Bench responder acks each transfer in 1 cycle and returns 0xDEADBEEF.
  - Required: exactly one read at 0x80000000, then one write of 0xDEADBEEF to 0x80000100 with sel=F. Then done=1, irq=1, LEN=0.
  - Cycle spacing: the stb=1 cycles of the read and write are 2 cycles apart.
- Burst of 4 with variable ack latency (0-5 wait states):
  - Writes go to DST+0, +4, +8, +C and match the source pattern.
  - cyc is never high across a gap cycle.
  - SRC and DST end at base+0x10.
- Error abort: LEN=3; responder asserts dma_err on the 2nd read.
  - Required: err=1, done=0, busy=0, LEN=2, SRC=base+4, irq=1.
  - Writing 4 to CTRL clears err and irq.
- LEN=0 start: no dma_cyc ever asserted; done=1 by the cycle after the ack.
- Busy protection: a write of SRC=0x12345678 mid-transfer is acked but ignored; the copy completes with the original addresses. A SRC write of 0x12345677 when idle reads back as 0x12345674.
